// File: rtl/cim_pkg.sv
// Shared types and helpers for the CIM crossbar tile: FSM state encoding,
// accumulator sizing and the ADC-style shift-and-saturate transfer function.
package cim_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        ADC,
        UPDATE
    } state_e;

    localparam int unsigned XBAR_SIZE_DEFAULT     = 512;
    localparam int unsigned DATATYPE_SIZE_DEFAULT = 2;
    localparam int unsigned SAT_W                 = 32;

    // Wide enough for xbar_size rows of the largest input element.
    function automatic int unsigned acc_width(input int unsigned xbar, input int unsigned dw);
        return dw + $clog2(xbar);
    endfunction

    function automatic logic [SAT_W-1:0] sat_shift(input logic [SAT_W-1:0] acc,
                                                   input int unsigned      shift,
                                                   input int unsigned      width);
        logic [SAT_W-1:0] shifted;
        logic [SAT_W-1:0] max_v;
        shifted = acc >> shift;
        max_v   = (SAT_W'(1) << width) - SAT_W'(1);
        return (shifted > max_v) ? max_v : shifted;
    endfunction

endpackage

// File: rtl/cim_xbar_tile_col_accum.sv
// One crossbar column: binary-weighted accumulation of the input vector and
// the shifted, saturated ADC view of the running sum.
module cim_col_accum
    import cim_pkg::*;
#(
    parameter int unsigned DATATYPE_SIZE = 2,
    parameter int unsigned ACC_W         = 11,
    parameter int unsigned OUT_SHIFT     = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic                     w_bit,
    input  logic [DATATYPE_SIZE-1:0] in_data,
    output logic [DATATYPE_SIZE-1:0] result
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en && w_bit) begin
            acc_d = acc_q + ACC_W'(in_data);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    always_comb begin
        result = DATATYPE_SIZE'(sat_shift(SAT_W'(acc_q), OUT_SHIFT, DATATYPE_SIZE));
    end

endmodule

// File: rtl/cim_xbar_tile.sv
// CIM crossbar tile responder: buffers an input vector, runs one binary-weight
// MVM row per cycle, then publishes saturated per-column results for readback.
module cim_xbar_tile
    import cim_pkg::*;
#(
    parameter int unsigned xbar_size     = XBAR_SIZE_DEFAULT,
    parameter int unsigned datatype_size = DATATYPE_SIZE_DEFAULT,
    parameter int unsigned adc_latency   = 4,
    parameter int unsigned out_shift     = $clog2(xbar_size)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_wr_en,
    input  logic [$clog2(xbar_size)-1:0] i_wr_addr,
    input  logic [datatype_size-1:0]     i_wr_data,
    input  logic                         i_exec,
    output logic                         o_busy,
    output logic                         o_done,
    input  logic [$clog2(xbar_size)-1:0] i_rd_addr,
    output logic [datatype_size-1:0]     o_rd_data,
    input  logic                         i_prog_we,
    input  logic [$clog2(xbar_size)-1:0] i_prog_row,
    input  logic [xbar_size-1:0]         i_prog_data
);

    localparam int unsigned AW    = $clog2(xbar_size);
    localparam int unsigned ACC_W = acc_width(xbar_size, datatype_size);
    localparam int unsigned CW    = $clog2(adc_latency) + 1;

    state_e state_q, state_d;

    logic [AW-1:0]            row_q, row_d;
    logic [CW-1:0]            adc_cnt_q, adc_cnt_d;
    logic [datatype_size-1:0] ibuf_q [xbar_size];
    logic [datatype_size-1:0] ibuf_d [xbar_size];
    logic [xbar_size-1:0]     w_q [xbar_size];
    logic [xbar_size-1:0]     w_d [xbar_size];
    logic [datatype_size-1:0] res_q [xbar_size];
    logic [datatype_size-1:0] res_d [xbar_size];
    logic [datatype_size-1:0] col_res [xbar_size];
    logic [datatype_size-1:0] rd_data_q, rd_data_d;

    logic                     idle, busy, done, acc_clr, acc_en;
    logic [xbar_size-1:0]     w_row;
    logic [datatype_size-1:0] in_row;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (i_exec) state_d = COMPUTE;
            COMPUTE: if (row_q == AW'(xbar_size - 1)) state_d = ADC;
            ADC:     if (adc_cnt_q == CW'(adc_latency - 1)) state_d = UPDATE;
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idle    = (state_q == IDLE);
        busy    = (state_q == COMPUTE) || (state_q == ADC);
        done    = (state_q == UPDATE);
        acc_clr = idle && i_exec;
        acc_en  = (state_q == COMPUTE);
    end

    always_comb begin
        row_d     = row_q;
        adc_cnt_d = adc_cnt_q;
        if (acc_clr) begin
            row_d = '0;
        end
        if (state_q == COMPUTE) begin
            row_d     = row_q + AW'(1);
            adc_cnt_d = '0;
        end
        if (state_q == ADC) begin
            adc_cnt_d = adc_cnt_q + CW'(1);
        end
    end

    // Writes land only in IDLE; results are copied out of the columns on UPDATE,
    // so reads during an MVM keep returning the previous result set.
    always_comb begin
        ibuf_d = ibuf_q;
        w_d    = w_q;
        res_d  = res_q;
        if (idle && i_wr_en) begin
            ibuf_d[i_wr_addr] = i_wr_data;
        end
        if (idle && i_prog_we) begin
            w_d[i_prog_row] = i_prog_data;
        end
        if (done) begin
            res_d = col_res;
        end
        rd_data_d = res_q[i_rd_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            row_q     <= '0;
            adc_cnt_q <= '0;
            rd_data_q <= '0;
            for (int unsigned i = 0; i < xbar_size; i++) begin
                ibuf_q[i] <= '0;
                w_q[i]    <= '0;
                res_q[i]  <= '0;
            end
        end else begin
            row_q     <= row_d;
            adc_cnt_q <= adc_cnt_d;
            rd_data_q <= rd_data_d;
            ibuf_q    <= ibuf_d;
            w_q       <= w_d;
            res_q     <= res_d;
        end
    end

    always_comb begin
        w_row  = w_q[row_q];
        in_row = ibuf_q[row_q];
    end

    for (genvar c = 0; c < xbar_size; c++) begin : g_col
        cim_col_accum #(
            .DATATYPE_SIZE(datatype_size),
            .ACC_W        (ACC_W),
            .OUT_SHIFT    (out_shift)
        ) u_col (
            .clk    (clk),
            .rst    (rst),
            .clr    (acc_clr),
            .en     (acc_en),
            .w_bit  (w_row[c]),
            .in_data(in_row),
            .result (col_res[c])
        );
    end

    assign o_busy    = busy;
    assign o_done    = done;
    assign o_rd_data = rd_data_q;

endmodule
